// File: rtl/pc_redirect_if.sv
// Fetch-side bundle of the PC redirect controller: the redirect request from
// execute, the instruction-memory request handshake, and the decode-facing status.
interface pc_redirect_if #(
   parameter int XLEN = 32
);
   logic            redir_valid;
   logic [XLEN-1:0] redir_target;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] fetch_pc;
   logic            kill;
   logic            misalign;
   logic [31:0]     redir_count;

   // Producer/environment side: issues redirects and answers the fetch request.
   modport master (
      output redir_valid,
      output redir_target,
      output imem_req_ready,
      input  imem_req_valid,
      input  imem_addr,
      input  fetch_pc,
      input  kill,
      input  misalign,
      input  redir_count
   );

   // Controller side: owns the fetch PC and drives the imem request.
   modport slave (
      input  redir_valid,
      input  redir_target,
      input  imem_req_ready,
      output imem_req_valid,
      output imem_addr,
      output fetch_pc,
      output kill,
      output misalign,
      output redir_count
   );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner for the 3-stage core: sequential fetch, redirect bypass/hold, kill pulses.
// Optional redirect statistics counter is built when PC_REDIRECT_STATS_EN is defined.
module pc_redirect_ctrl #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h4000_0000),
   parameter int              KILL_CYCLES = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         stall,
   pc_redirect_if.slave bus
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } state_t;

   localparam logic [1:0] KILL_LOAD = 2'(KILL_CYCLES);

   state_t          state_q;
   state_t          state_d;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] fetch_pc_q;
   logic [XLEN-1:0] pend_target_q;
   logic [1:0]      kill_cnt_q;
   logic            misalign_q;

   logic            redir_acc;
   logic            req_valid;
   logic            req_fire;
   logic [XLEN-1:0] req_addr;
   logic [XLEN-1:0] eff_target;

   function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
      return t & ~XLEN'(3);
   endfunction

   function automatic logic [XLEN-1:0] next_seq(input logic [XLEN-1:0] a);
      return a + XLEN'(4);
   endfunction

   assign eff_target = align_target(bus.redir_target);

   // A fresh redirect always takes priority for the address so it is visible
   // the same cycle it arrives and stays stable while it waits in PEND.
   always_comb begin
      state_d   = state_q;
      redir_acc = 1'b0;
      req_valid = 1'b0;
      req_fire  = 1'b0;
      req_addr  = pc_q;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end
         ST_RUN, ST_PEND: begin
            redir_acc = bus.redir_valid;
            req_valid = !stall;
            if (redir_acc) begin
               req_addr = eff_target;
            end else if (state_q == ST_PEND) begin
               req_addr = pend_target_q;
            end else begin
               req_addr = pc_q;
            end
            req_fire = req_valid && bus.imem_req_ready;
            if (req_fire) begin
               state_d = ST_RUN;
            end else if (redir_acc) begin
               state_d = ST_PEND;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         fetch_pc_q <= RESET_PC;
      end else if (req_fire) begin
         fetch_pc_q <= req_addr;
         pc_q       <= next_seq(req_addr);
      end
   end

   // Youngest redirect wins while waiting for the fetch port.
   always_ff @(posedge clk) begin
      if (!rst && redir_acc) begin
         pend_target_q <= eff_target;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         kill_cnt_q <= 2'd0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= redir_acc && bus.redir_target[1];
         if (redir_acc) begin
            kill_cnt_q <= KILL_LOAD;
         end else if (!stall && kill_cnt_q != 2'd0) begin
            kill_cnt_q <= kill_cnt_q - 2'd1;
         end
      end
   end

`ifdef PC_REDIRECT_STATS_EN
   logic [31:0] redir_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         redir_count_q <= 32'd0;
      end else if (redir_acc) begin
         redir_count_q <= redir_count_q + 32'd1;
      end
   end

   assign bus.redir_count = redir_count_q;
`else
   assign bus.redir_count = 32'd0;
`endif

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_addr      = req_addr;
   assign bus.fetch_pc       = fetch_pc_q;
   assign bus.kill           = (kill_cnt_q != 2'd0);
   assign bus.misalign       = misalign_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level fetch model.
module tb_pc_redirect_ctrl;
   localparam int          XLEN = 32;
   localparam logic [31:0] RPC  = 32'h4000_0000;
   localparam int          KC   = 1;

   logic clk = 1'b0;
   logic rst;
   logic stall;

   always #5 clk = ~clk;

   pc_redirect_if #(.XLEN(XLEN)) bus ();

   pc_redirect_ctrl #(
      .XLEN(XLEN),
      .RESET_PC(RPC),
      .KILL_CYCLES(KC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .bus(bus.slave)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model state: where fetch stands, described as "booting", "a redirect waiting", etc.
   bit          model_ok = 1'b0;
   bit          m_booting;
   bit          m_waiting;
   logic [31:0] m_wait_target;
   logic [31:0] m_next_pc;
   logic [31:0] m_last_fetch;
   int          m_kill_left;
   bit          m_misalign;
   logic [31:0] m_count;

   logic        cap_valid;
   logic [31:0] cap_addr;
   logic [31:0] cap_fetch;
   logic        cap_kill;
   logic        cap_mis;
   logic [31:0] cap_cnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step(input bit r, input bit s, input bit rv, input logic [31:0] t, input bit rdy);
      bit          taken;
      bit          exp_valid;
      logic [31:0] exp_addr;
      logic [31:0] aligned;
      rst                = r;
      stall              = s;
      bus.redir_valid    = rv;
      bus.redir_target   = t;
      bus.imem_req_ready = rdy;
      @(negedge clk);
      cap_valid = bus.imem_req_valid;
      cap_addr  = bus.imem_addr;
      cap_fetch = bus.fetch_pc;
      cap_kill  = bus.kill;
      cap_mis   = bus.misalign;
      cap_cnt   = bus.redir_count;

      aligned   = {t[31:2], 2'b00};
      taken     = rv && !m_booting;
      exp_valid = !m_booting && !s;
      if (taken)          exp_addr = aligned;
      else if (m_waiting) exp_addr = m_wait_target;
      else                exp_addr = m_next_pc;

      if (model_ok) begin
         chk("req_valid", {31'd0, cap_valid}, {31'd0, exp_valid});
         if (exp_valid) chk("imem_addr", cap_addr, exp_addr);
         chk("fetch_pc", cap_fetch, m_last_fetch);
         chk("kill", {31'd0, cap_kill}, {31'd0, m_kill_left > 0});
         chk("misalign", {31'd0, cap_mis}, {31'd0, m_misalign});
`ifdef PC_REDIRECT_STATS_EN
         chk("redir_count", cap_cnt, m_count);
`else
         chk("redir_count", cap_cnt, 32'd0);
`endif
      end

      if (r) begin
         model_ok     = 1'b1;
         m_booting    = 1'b1;
         m_waiting    = 1'b0;
         m_next_pc    = RPC;
         m_last_fetch = RPC;
         m_kill_left  = 0;
         m_misalign   = 1'b0;
         m_count      = 32'd0;
      end else if (model_ok) begin
         m_booting  = 1'b0;
         m_misalign = taken && t[1];
         if (taken) m_count = m_count + 32'd1;
         if (exp_valid && rdy) begin
            m_last_fetch = exp_addr;
            m_next_pc    = exp_addr + 32'd4;
            m_waiting    = 1'b0;
         end else if (taken) begin
            m_waiting     = 1'b1;
            m_wait_target = aligned;
         end
         if (taken) m_kill_left = KC;
         else if (!s && m_kill_left > 0) m_kill_left = m_kill_left - 1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] tgt;
      // Reset and sequential fetch after the BOOT cycle.
      step(1, 0, 0, 32'h0, 1);
      step(1, 0, 0, 32'h0, 1);
      chk("rst_fetch_pc", cap_fetch, 32'h4000_0000);
      chk("rst_kill", {31'd0, cap_kill}, 32'd0);
      step(0, 0, 0, 32'h0, 1);
      chk("boot_no_req", {31'd0, cap_valid}, 32'd0);
      step(0, 0, 0, 32'h0, 1);
      chk("seq0", cap_addr, 32'h4000_0000);
      step(0, 0, 0, 32'h0, 1);
      chk("seq1", cap_addr, 32'h4000_0004);
      step(0, 0, 0, 32'h0, 1);
      chk("seq2", cap_addr, 32'h4000_0008);

      // Immediate redirect with bypass and a single kill cycle.
      step(0, 0, 1, 32'h1000_0010, 1);
      chk("redir_bypass", cap_addr, 32'h1000_0010);
      chk("redir_no_kill_yet", {31'd0, cap_kill}, 32'd0);
      step(0, 0, 0, 32'h0, 1);
      chk("redir_next", cap_addr, 32'h1000_0014);
      chk("redir_kill", {31'd0, cap_kill}, 32'd1);
      step(0, 0, 0, 32'h0, 1);
      chk("kill_done", {31'd0, cap_kill}, 32'd0);

      // Redirect held while the fetch port is busy.
      step(0, 0, 1, 32'h2000_0000, 0);
      step(0, 0, 0, 32'h0, 0);
      chk("pend_hold1", cap_addr, 32'h2000_0000);
      step(0, 0, 0, 32'h0, 0);
      chk("pend_hold2", cap_addr, 32'h2000_0000);
      step(0, 0, 0, 32'h0, 1);
      chk("pend_issue", cap_addr, 32'h2000_0000);
      step(0, 0, 0, 32'h0, 1);
      chk("pend_fetch_pc", cap_fetch, 32'h2000_0000);
      chk("pend_next", cap_addr, 32'h2000_0004);

      // Youngest redirect wins in PEND.
      step(1, 0, 0, 32'h0, 1);
      step(0, 0, 0, 32'h0, 1);
      step(0, 0, 1, 32'h2000_0000, 0);
      step(0, 0, 1, 32'h3000_0040, 0);
      step(0, 0, 0, 32'h0, 1);
      chk("overwrite_issue", cap_addr, 32'h3000_0040);
`ifdef PC_REDIRECT_STATS_EN
      chk("overwrite_count", cap_cnt, 32'd2);
`endif
      step(0, 0, 0, 32'h0, 1);
      chk("overwrite_fetch", cap_fetch, 32'h3000_0040);

      // Misaligned target and address wrap.
      step(0, 0, 1, 32'h0000_0102, 1);
      chk("mis_aligned_addr", cap_addr, 32'h0000_0100);
      step(0, 0, 0, 32'h0, 1);
      chk("mis_pulse", {31'd0, cap_mis}, 32'd1);
      step(0, 0, 0, 32'h0, 1);
      chk("mis_clear", {31'd0, cap_mis}, 32'd0);
      step(0, 0, 1, 32'hFFFF_FFFC, 1);
      step(0, 0, 0, 32'h0, 1);
      chk("wrap", cap_addr, 32'h0000_0000);

      // Stall stretches kill; reset in PEND drops everything.
      step(0, 1, 1, 32'h5000_0000, 1);
      step(0, 1, 0, 32'h0, 1);
      chk("stall_kill", {31'd0, cap_kill}, 32'd1);
      chk("stall_no_req", {31'd0, cap_valid}, 32'd0);
      step(1, 0, 0, 32'h0, 0);
      step(0, 0, 0, 32'h0, 1);
      chk("rst_pend_kill", {31'd0, cap_kill}, 32'd0);
      chk("rst_pend_count", cap_cnt, 32'd0);
      step(0, 0, 0, 32'h0, 1);
      chk("rst_pend_resume", cap_addr, 32'h4000_0000);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         tgt = $urandom & 32'hFFFF_FFFE;
         if ($urandom_range(0, 31) == 0) tgt = 32'hFFFF_FFFC;
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0,
              tgt,
              $urandom_range(0, 3) != 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
